// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
   typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

   // Expected parity bit for a word whose unused upper bits are zero.
   function automatic logic parity_bit(input logic [8:0] data, input parity_e mode);
      case (mode)
         PAR_EVEN: return ^data;
         PAR_ODD:  return ~(^data);
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; shared by the RX line and the TX CTS input.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: non-blocking assignments so the second flop takes the first flop's pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: configurable data/parity/stop format, error flags and a
// single-entry valid/ready holding register with overrun reporting.
module uart_rx_core #(
   parameter int                CLKS_PER_BIT = 22274,
   parameter int                DATA_BITS    = 8,
   parameter uart_pkg::parity_e PARITY       = uart_pkg::PAR_NONE,
   parameter int                STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 i_reset_n,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int               IDX_W     = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = (STOP_BITS == 2);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_core: DATA_BITS must be in 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_core: STOP_BITS must be 1 or 2");
   end
   if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_rx_core: CLKS_PER_BIT must be at least 4");
   end

   uart_pkg::rx_state_e  state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 par_err;
   logic                 frame_err;
   logic                 rx_s;
   logic                 half_done;
   logic                 bit_done;
   logic                 stop_err;
   logic                 can_load;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (i_reset_n),
      .d     (i_rx),
      .q     (rx_s)
   );

   assign half_done = (cnt == HALF_LAST);
   assign bit_done  = (cnt == FULL_LAST);
   assign stop_err  = frame_err | ~rx_s;
   // The holding register is free if empty or being drained in this very cycle.
   assign can_load  = ~o_valid | i_ready;

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state        <= uart_pkg::IDLE;
         cnt          <= '0;
         idx          <= '0;
         stop_idx     <= 1'b0;
         shift        <= '0;
         par_err      <= 1'b0;
         frame_err    <= 1'b0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_overrun    <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         if (o_valid && i_ready) o_valid <= 1'b0;

         case (state)
            uart_pkg::IDLE: begin
               cnt <= '0;
               if (!rx_s) begin
                  state     <= uart_pkg::START;
                  o_busy    <= 1'b1;
                  par_err   <= 1'b0;
                  frame_err <= 1'b0;
                  stop_idx  <= 1'b0;
               end
            end
            uart_pkg::START: begin
               if (half_done) begin
                  cnt <= '0;
                  idx <= '0;
                  if (!rx_s) begin
                     state <= uart_pkg::DATA;
                  end else begin
                     state  <= uart_pkg::IDLE;
                     o_busy <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            uart_pkg::DATA: begin
               if (bit_done) begin
                  cnt        <= '0;
                  shift[idx] <= rx_s;
                  idx        <= idx + 1'b1;
                  if (idx == LAST_IDX)
                     state <= (PARITY != uart_pkg::PAR_NONE) ? uart_pkg::PARITY : uart_pkg::STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            uart_pkg::PARITY: begin
               if (bit_done) begin
                  cnt     <= '0;
                  par_err <= (rx_s != uart_pkg::parity_bit(9'(shift), PARITY));
                  state   <= uart_pkg::STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            uart_pkg::STOP: begin
               if (bit_done) begin
                  cnt <= '0;
                  if (stop_idx == LAST_STOP) begin
                     // Leave mid-stop-bit so a directly following start edge is caught.
                     state  <= uart_pkg::IDLE;
                     o_busy <= 1'b0;
                     if (can_load) begin
                        o_data       <= shift;
                        o_parity_err <= par_err;
                        o_frame_err  <= stop_err;
                        o_valid      <= 1'b1;
                     end else begin
                        o_overrun <= 1'b1;
                     end
                  end else begin
                     stop_idx  <= 1'b1;
                     frame_err <= stop_err;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= uart_pkg::IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: three frame formats (8N1, 7E2, 9O1) driven by a bit-level line model.
module tb_uart_rx_core;
   import uart_pkg::*;

   localparam int C  = 16;
   localparam int NI = 3;

   typedef struct {
      int         inst;
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } rec_t;

   typedef struct {
      int         inst;
      logic [8:0] data;
      logic       pflip;
      logic [1:0] stop_low;
      logic [8:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NI-1:0] rx;
   logic [NI-1:0] ready;
   logic [NI-1:0] valid;
   logic [NI-1:0] perr;
   logic [NI-1:0] ferr;
   logic [NI-1:0] ovr;
   logic [NI-1:0] busy;
   logic [7:0]    d0;
   logic [6:0]    d1;
   logic [8:0]    d2;

   int   n_checks = 0;
   int   n_fail   = 0;
   rec_t got_q[$];
   int   ovr_cnt[NI] = '{0, 0, 0};

   always #5 clk = ~clk;

   uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .i_reset_n(rst_n), .i_rx(rx[0]), .o_data(d0), .o_valid(valid[0]), .i_ready(ready[0]),
      .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_overrun(ovr[0]), .o_busy(busy[0]));

   uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2)) u_7e2 (
      .clk(clk), .i_reset_n(rst_n), .i_rx(rx[1]), .o_data(d1), .o_valid(valid[1]), .i_ready(ready[1]),
      .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_overrun(ovr[1]), .o_busy(busy[1]));

   uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(9), .PARITY(PAR_ODD), .STOP_BITS(1)) u_9o1 (
      .clk(clk), .i_reset_n(rst_n), .i_rx(rx[2]), .o_data(d2), .o_valid(valid[2]), .i_ready(ready[2]),
      .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_overrun(ovr[2]), .o_busy(busy[2]));

   // Frame format of each instance.
   function automatic int db(input int k);
      case (k)
         0:       return 8;
         1:       return 7;
         default: return 9;
      endcase
   endfunction

   function automatic int par_mode(input int k);  // 0 none, 1 even, 2 odd
      return k;
   endfunction

   function automatic int sb(input int k);
      return (k == 1) ? 2 : 1;
   endfunction

   function automatic logic [8:0] dout(input int k);
      case (k)
         0:       return {1'b0, d0};
         1:       return {2'b00, d1};
         default: return d2;
      endcase
   endfunction

   function automatic logic good_pbit(input int k, input logic [8:0] data);
      int ones;
      ones = $countones(data);
      return (par_mode(k) == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
   endfunction

   // Consumer-side monitor: every handshake and every overrun pulse.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (valid[k] && ready[k])
            got_q.push_back('{inst: k, data: dout(k), perr: perr[k], ferr: ferr[k]});
         if (ovr[k]) ovr_cnt[k]++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic check_b(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, got, exp);
      end
   endtask

   // Bit-accurate line model: start, data LSB first, optional parity, stop bits (stop_low[i] pulls stop i low).
   task automatic send_frame(input int k, input logic [8:0] data, input logic pbit, input logic [1:0] stop_low);
      logic line[$];
      line = {};
      line.push_back(1'b0);
      for (int i = 0; i < db(k); i++) line.push_back(data[i]);
      if (par_mode(k) != 0) line.push_back(pbit);
      for (int i = 0; i < sb(k); i++) line.push_back(~stop_low[i]);
      @(posedge clk); #1;
      foreach (line[i]) begin
         rx[k] = line[i];
         repeat (C) @(posedge clk);
         #1;
      end
      rx[k] = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      repeat (n * C) @(posedge clk);
      #1;
   endtask

   task automatic expect_rec(input string name, input int k, input logic [8:0] d, input logic pe, input logic fe);
      rec_t r;
      int   waited;
      waited = 0;
      while (got_q.size() == 0 && waited < 4 * C) begin
         @(posedge clk); #1;
         waited++;
      end
      check_b({name, " delivered"}, got_q.size() != 0, 1'b1);
      if (got_q.size() != 0) begin
         r = got_q.pop_front();
         check({name, " inst"}, 32'(r.inst), 32'(k));
         check({name, " data"}, 32'(r.data), 32'(d));
         check_b({name, " parity_err"}, r.perr, pe);
         check_b({name, " frame_err"}, r.ferr, fe);
      end
   endtask

   // Commit edge relative to the edge before the start bit: 3 sync/detect cycles, half a bit, then one period per bit.
   function automatic int commit_edge(input int k);
      return 3 + C / 2 + C * (db(k) + ((par_mode(k) != 0) ? 1 : 0) + sb(k));
   endfunction

   vec_t vecs[9];

   initial begin
      int ovr0;
      int k0;

      vecs[0] = '{0, 9'h0A5, 1'b0, 2'b00, 9'h0A5, 1'b0, 1'b0};
      vecs[1] = '{0, 9'h000, 1'b0, 2'b01, 9'h000, 1'b0, 1'b1};
      vecs[2] = '{0, 9'h0FF, 1'b0, 2'b00, 9'h0FF, 1'b0, 1'b0};
      vecs[3] = '{1, 9'h035, 1'b0, 2'b00, 9'h035, 1'b0, 1'b0};
      vecs[4] = '{1, 9'h035, 1'b1, 2'b00, 9'h035, 1'b1, 1'b0};
      vecs[5] = '{1, 9'h07F, 1'b0, 2'b10, 9'h07F, 1'b0, 1'b1};
      vecs[6] = '{1, 9'h000, 1'b0, 2'b01, 9'h000, 1'b0, 1'b1};
      vecs[7] = '{2, 9'h1FF, 1'b0, 2'b00, 9'h1FF, 1'b0, 1'b0};
      vecs[8] = '{2, 9'h100, 1'b1, 2'b00, 9'h100, 1'b1, 1'b0};

      rst_n = 1'b0;
      rx    = '1;
      ready = '1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("reset data%0d", k), 32'(dout(k)), 32'd0);
      end
      check("reset valid", 32'(valid), 32'd0);
      check("reset parity_err", 32'(perr), 32'd0);
      check("reset frame_err", 32'(ferr), 32'd0);
      check("reset overrun", 32'(ovr), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      idle_bits(1);

      // 8N1 0xA5: START latency, commit timing and a one-cycle o_valid pulse.
      k0 = commit_edge(0);
      fork
         send_frame(0, 9'h0A5, 1'b0, 2'b00);
         begin
            @(posedge clk);
            repeat (2) @(posedge clk);
            #1;
            check_b("8n1 idle before start", busy[0], 1'b0);
            @(posedge clk); #1;
            check_b("8n1 start latency", busy[0], 1'b1);
            repeat (k0 - 4) @(posedge clk);
            #1;
            check_b("8n1 no valid before commit", valid[0], 1'b0);
            check_b("8n1 busy before commit", busy[0], 1'b1);
            @(posedge clk); #1;
            check_b("8n1 valid after commit", valid[0], 1'b1);
            check("8n1 data after commit", 32'(d0), 32'h0A5);
            check_b("8n1 idle after commit", busy[0], 1'b0);
            @(posedge clk); #1;
            check_b("8n1 valid one cycle", valid[0], 1'b0);
         end
      join
      expect_rec("8n1 a5", 0, 9'h0A5, 1'b0, 1'b0);
      idle_bits(1);

      // Directed vectors across all three formats.
      for (int i = 0; i < 9; i++) begin
         send_frame(vecs[i].inst, vecs[i].data, good_pbit(vecs[i].inst, vecs[i].data) ^ vecs[i].pflip,
                    vecs[i].stop_low);
         idle_bits(2);
         expect_rec($sformatf("vec%0d", i), vecs[i].inst, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
      end

      // Glitch: 5-cycle low pulse must be rejected at the half-bit sample.
      @(posedge clk); #1;
      rx[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rx[0] = 1'b1;
      check_b("glitch busy seen", busy[0], 1'b1);
      repeat (10) @(posedge clk);
      #1;
      check_b("glitch busy cleared", busy[0], 1'b0);
      check_b("glitch no valid", valid[0], 1'b0);
      check("glitch no frame", 32'(got_q.size()), 32'd0);
      idle_bits(1);

      // Overrun: second frame dropped while the first is held.
      ready[0] = 1'b0;
      ovr0 = ovr_cnt[0];
      send_frame(0, 9'h011, 1'b0, 2'b00);
      send_frame(0, 9'h022, 1'b0, 2'b00);
      idle_bits(1);
      check_b("overrun held valid", valid[0], 1'b1);
      check("overrun held data", 32'(d0), 32'h011);
      check("overrun pulse count", 32'(ovr_cnt[0] - ovr0), 32'd1);
      ready[0] = 1'b1;
      @(posedge clk); #1;
      check_b("overrun valid drops", valid[0], 1'b0);
      expect_rec("overrun accept", 0, 9'h011, 1'b0, 1'b0);
      check("overrun nothing more", 32'(got_q.size()), 32'd0);
      idle_bits(1);

      // Handshake in the exact commit cycle of the next frame.
      ready[0] = 1'b0;
      ovr0 = ovr_cnt[0];
      send_frame(0, 9'h011, 1'b0, 2'b00);
      fork
         send_frame(0, 9'h022, 1'b0, 2'b00);
         begin
            @(posedge clk);
            repeat (k0 - 1) @(posedge clk);
            #1;
            check_b("hs held valid", valid[0], 1'b1);
            check("hs held data", 32'(d0), 32'h011);
            ready[0] = 1'b1;
            @(posedge clk); #1;
            check_b("hs new valid", valid[0], 1'b1);
            check("hs new data", 32'(d0), 32'h022);
         end
      join
      expect_rec("hs first", 0, 9'h011, 1'b0, 1'b0);
      expect_rec("hs second", 0, 9'h022, 1'b0, 1'b0);
      check("hs no overrun", 32'(ovr_cnt[0] - ovr0), 32'd0);
      idle_bits(1);

      // Reset during data bit 3 with a frame held.
      ready[0] = 1'b0;
      send_frame(0, 9'h033, 1'b0, 2'b00);
      idle_bits(1);
      fork
         send_frame(0, 9'h05A, 1'b0, 2'b00);
         begin
            @(posedge clk);
            repeat (4 * C + C / 2) @(posedge clk);
            #1;
            check_b("rst pre busy", busy[0], 1'b1);
            check_b("rst pre valid", valid[0], 1'b1);
            rst_n = 1'b0;
            #1;
            check_b("rst async valid", valid[0], 1'b0);
            check("rst async data", 32'(d0), 32'd0);
            check_b("rst async busy", busy[0], 1'b0);
            check_b("rst async parity_err", perr[0], 1'b0);
            check_b("rst async frame_err", ferr[0], 1'b0);
            check_b("rst async overrun", ovr[0], 1'b0);
         end
      join
      @(posedge clk); #1;
      rst_n    = 1'b1;
      ready[0] = 1'b1;
      idle_bits(1);
      check("rst nothing committed", 32'(got_q.size()), 32'd0);
      send_frame(0, 9'h05A, 1'b0, 2'b00);
      idle_bits(1);
      expect_rec("rst clean 5a", 0, 9'h05A, 1'b0, 1'b0);

      // Random frames against the frame-level model.
      ready = '1;
      for (int k = 0; k < NI; k++) begin
         ovr0 = ovr_cnt[k];
         for (int i = 0; i < 10; i++) begin
            logic [8:0] data;
            logic       pbit;
            logic [1:0] stop_low;
            logic       exp_perr;
            int         ones;
            data     = 9'($urandom) & 9'((1 << db(k)) - 1);
            pbit     = 1'($urandom_range(0, 1));
            stop_low = 2'b00;
            for (int s = 0; s < sb(k); s++) stop_low[s] = ($urandom_range(0, 5) == 0);
            ones     = $countones(data) + ((par_mode(k) != 0) ? int'(pbit) : 0);
            exp_perr = (par_mode(k) != 0) && ((ones % 2) != ((par_mode(k) == 2) ? 1 : 0));
            send_frame(k, data, pbit, stop_low);
            expect_rec($sformatf("rand%0d_%0d", k, i), k, data, exp_perr, |stop_low);
            if (stop_low[sb(k) - 1]) idle_bits(2);
            else idle_bits($urandom_range(0, 1));
         end
         check($sformatf("rand%0d overrun", k), 32'(ovr_cnt[k] - ovr0), 32'd0);
      end

      check("final queue empty", 32'(got_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive core. It replaces the fixed 8N1 receiver with configurable frame format (data bits, parity, stop bits), input synchronisation, error reporting and a valid/ready output handshake. It sits between the board RX pin and any byte consumer: FIFO, command decoder or loopback.

## Interface
- CLKS_PER_BIT, default 22274: clock cycles per bit period; must be ≥ 4.
- DATA_BITS, default 8: data bits per frame, legal range 5..9.
- PARITY, default PAR_NONE: parity mode, one of PAR_NONE, PAR_EVEN, PAR_ODD (uart_pkg::parity_e).
- STOP_BITS, default 1: stop bits per frame, 1 or 2.
- clk  input  1  the single clock; all logic on posedge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_rx  input  1  serial line, idle high, asynchronous to clk.
- o_data  output  DATA_BITS  received word; bit 0 is the first data bit on the line (LSB-first).
- o_valid  output  1  o_data and error flags hold a frame.
- i_ready  input  1  consumer accepts the frame in the cycle where o_valid && i_ready.
- o_parity_err  output  1  parity mismatch for the held frame; always 0 when PARITY = PAR_NONE.
- o_frame_err  output  1  a stop bit was sampled low for the held frame.
- o_overrun  output  1  one-cycle pulse: a completed frame was dropped because the holding register was full.
- o_busy  output  1  the FSM is not in IDLE.

## Operation
- i_rx passes through a 2-flop synchroniser reset to 1. The FSM sees only the synchronised value, rx_s.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- **IDLE**: when rx_s = 0, clear the counter and go to START.
- **START**: count to CLKS_PER_BIT/2 − 1 (integer division), then sample.
  - If rx_s = 0: go to DATA with bit index 0 and the counter cleared.
  - If rx_s = 1: treat it as a glitch and return to IDLE; no output, no error.
- **DATA**: count CLKS_PER_BIT − 1, then sample rx_s into shift bit [index].
  - After bit DATA_BITS−1, go to PARITY if PARITY ≠ PAR_NONE, otherwise go to STOP.
- **PARITY**: after a full bit period, sample the line.
  - par_err = (XOR of data bits ^ sampled bit) ≠ (PARITY == PAR_ODD).
- **STOP**: after a full bit period, sample the line; a low sample sets frame_err.
  - With STOP_BITS = 2, repeat once more. frame_err is the OR of both samples.
  - After the last stop sample, go to IDLE immediately (mid-stop-bit), so back-to-back frames are received.
- **Commit** happens in the last stop-sample cycle.
  - If o_valid = 0, or o_valid && i_ready in that same cycle: load o_data, o_parity_err and o_frame_err, and set o_valid.
  - Otherwise, drop the new frame, keep the held frame, and pulse o_overrun.
- o_valid clears the cycle after handshake unless a commit happens in that same cycle.
- Frames with errors are still delivered with their flags set; the consumer decides what to discard.
- Counter width is $clog2(CLKS_PER_BIT); it never exceeds CLKS_PER_BIT − 1. The bit index is $clog2(DATA_BITS) wide.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, counter = 0, index = 0, synchroniser = 1.
  - o_data = 0, o_valid = 0, o_parity_err = 0, o_frame_err = 0, o_overrun = 0, o_busy = 0.
- Reset mid-frame abandons the frame; nothing is committed.
- Input-to-FSM latency is 2 cycles (synchroniser).
- The falling edge on i_rx reaches START 3 cycles later.
- o_valid rises 1 cycle after the final stop sample, about (1.5 + DATA_BITS + P + STOP_BITS − 1) × CLKS_PER_BIT + 3 cycles after the start edge, where P = 1 with parity and 0 without.
- o_overrun is high for exactly one cycle per dropped frame.
- i_ready is ignored while o_valid = 0.

## Structure
- uart_pkg holds:
  - typedef enum rx_state_e {IDLE, START, DATA, PARITY, STOP};
  - typedef enum parity_e {PAR_NONE, PAR_EVEN, PAR_ODD};
  - the function that computes the expected parity bit.
- Sub-module: uart_sync2, a 2-flop synchroniser with reset value parameter RESET_VAL = 1. It is reused later by the transmitter's CTS input.
- Elaboration-time checks reject:
  - DATA_BITS outside 5..9;
  - STOP_BITS outside 1..2;
  - CLKS_PER_BIT < 4.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and drive the line with a bit-accurate UART model.
- **8N1**: send 0xA5 with i_ready = 1.
  - o_valid pulses 1 cycle with o_data = 0xA5 and no error flags.
  - The FSM is in IDLE at the mid-stop sample plus 1.
- **7E2**: send 0x35 with a correct parity bit, no error. Then send 0x35 with the parity bit flipped: o_parity_err = 1 and o_data = 0x35.
- **Framing error and glitch**:
  - Send 0x00 with the stop bit held low: o_frame_err = 1.
  - A 5-cycle low glitch produces no o_valid and o_busy returns to 0.
- **Overrun**: with i_ready = 0, send 0x11 then 0x22 back-to-back.
  - o_data stays 0x11 and o_overrun pulses once.
  - Raise i_ready: 0x11 is accepted and o_valid drops.
- **Handshake at commit**: assert i_ready exactly in the cycle the second frame commits. Both 0x11 and 0x22 are delivered and there is no overrun.
- **Reset mid-frame**: assert i_reset_n = 0 during data bit 3.
  - All outputs go to 0 asynchronously.
  - The next clean frame 0x5A is received correctly.
